// File: rtl/cnn_mem_seq.sv
// cnn_mem_seq: image/weight store and layer sequencer for an external CNN pipeline.
//
// The host loads the input image (address 0) and one weight region per layer
// (addresses 1..NUM_LAYERS) as auto-incrementing write streams, then writes the
// control register to start. The sequencer pulses layer_start[k], waits for
// layer_done[k], and ping-pongs activations between buffers A and B. After
// the last layer the host drains the result through an auto-incrementing read
// stream (address 10) whose length is result_count (address 11).
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   chipselect/write/read/address  host register access
//   writedata / readdata           host data (readdata registered)
//   layer_start / layer_done       one-hot per-layer start/done handshake
//   act_rd_addr / act_rd_data      activation read port (1-cycle latency)
//   wt_rd_addr / wt_rd_data        weight read port for the running layer
//   out_wr_en/addr/data            running layer's output write port
//
// State table:
//   S_IDLE  | loaded or empty, waiting for a start command
//   S_PULSE | layer_start[k] asserted for this single cycle
//   S_WAIT  | layer k computing; read ports valid, output writes accepted
//   S_DONE  | all layers finished; result stream readable

module cnn_mem_seq #(
  parameter int DATA_W     = 8,
  parameter int NUM_LAYERS = 4,
  parameter int ACT_DEPTH  = 16384,
  parameter int WT_DEPTH   = 16384,
  localparam int ACT_AW    = $clog2(ACT_DEPTH),
  localparam int WT_AW     = $clog2(WT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic                  read,
  input  logic [3:0]            address,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic [ACT_AW-1:0]     act_rd_addr,
  output logic [DATA_W-1:0]     act_rd_data,
  input  logic [WT_AW-1:0]      wt_rd_addr,
  output logic [DATA_W-1:0]     wt_rd_data,
  input  logic                  out_wr_en,
  input  logic [ACT_AW-1:0]     out_wr_addr,
  input  logic [DATA_W-1:0]     out_wr_data
);

  localparam int KW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [KW-1:0]   K_LAST   = KW'(NUM_LAYERS - 1);
  localparam logic [KW-1:0]   K_ONE    = KW'(1);
  localparam logic [ACT_AW:0] ACT_FULL = (ACT_AW + 1)'(ACT_DEPTH);
  localparam logic [ACT_AW:0] ACT_ONE  = (ACT_AW + 1)'(1);
  localparam logic [WT_AW:0]  WT_FULL  = (WT_AW + 1)'(WT_DEPTH);
  localparam logic [WT_AW:0]  WT_ONE   = (WT_AW + 1)'(1);
  // Each layer flips buffers, so an even layer count ends back in A.
  localparam bit FINAL_IS_A = (NUM_LAYERS % 2) == 0;

  localparam logic [3:0] ADDR_INPUT  = 4'd0;
  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;
  localparam logic [3:0] ADDR_RESULT = 4'd10;
  localparam logic [3:0] ADDR_RCOUNT = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [KW-1:0]         r_k;
  logic [ACT_AW:0]       r_in_ptr;
  logic [WT_AW:0]        r_wt_ptr [NUM_LAYERS];
  logic [ACT_AW:0]       r_result_count;
  logic [ACT_AW:0]       r_rptr;
  logic                  r_err;
  logic [DATA_W-1:0]     r_readdata;
  logic [DATA_W-1:0]     r_act_rd_data;
  logic [DATA_W-1:0]     r_wt_rd_data;

  logic [DATA_W-1:0]     r_buf_a  [ACT_DEPTH];
  logic [DATA_W-1:0]     r_buf_b  [ACT_DEPTH];
  logic [DATA_W-1:0]     r_wt_mem [NUM_LAYERS][WT_DEPTH];

  logic                  w_wr, w_rd, w_busy, w_done, w_ctl;
  logic                  w_in_we, w_all_ne, w_in_ne;
  logic [NUM_LAYERS-1:0] w_wt_we;
  logic                  w_err_set, w_start, w_clear;
  logic                  w_out_we, w_layer_fin, w_rd_result;
  logic [ACT_AW:0]       w_out_cnt;
  logic [DATA_W-1:0]     w_final_word, w_status, w_rd_mux;

  assign w_wr     = chipselect & write;
  assign w_rd     = chipselect & read;
  assign w_busy   = (r_state == S_PULSE) || (r_state == S_WAIT);
  assign w_done   = (r_state == S_DONE);
  assign w_ctl    = w_wr && (address == ADDR_CTRL);
  assign w_in_ne  = (r_in_ptr != '0);
  assign w_out_we = (r_state == S_WAIT) && out_wr_en;
  assign w_out_cnt = {1'b0, out_wr_addr} + ACT_ONE;
  assign w_layer_fin = (r_state == S_WAIT) && layer_done[r_k];
  assign w_rd_result = w_rd && (address == ADDR_RESULT) && w_done &&
                       (r_rptr < r_result_count);

  // Host write decode and error detection.
  always_comb begin
    w_in_we   = 1'b0;
    w_wt_we   = '0;
    w_err_set = 1'b0;
    w_all_ne  = 1'b1;
    w_start   = 1'b0;
    w_clear   = 1'b0;
    for (int r = 0; r < NUM_LAYERS; r++) begin
      if (r_wt_ptr[r] == '0) w_all_ne = 1'b0;
      if (w_wr && (address == 4'(r + 1))) begin
        if (w_busy || (r_wt_ptr[r] == WT_FULL)) w_err_set = 1'b1;
        else                                    w_wt_we[r] = 1'b1;
      end
    end
    if (w_wr && (address == ADDR_INPUT)) begin
      if (w_busy || (r_in_ptr == ACT_FULL)) w_err_set = 1'b1;
      else                                  w_in_we   = 1'b1;
    end
    if (w_ctl) begin
      // Clear outranks start when both bits are written together.
      if (writedata[1]) begin
        if (w_busy) w_err_set = 1'b1;
        else        w_clear   = 1'b1;
      end else if (writedata[0]) begin
        if ((r_state == S_IDLE) && w_all_ne) w_start   = 1'b1;
        else                                 w_err_set = 1'b1;
      end
    end
  end

  // FSM next state and start pulse.
  always_comb begin
    w_state_nxt = r_state;
    layer_start = '0;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_PULSE;
      S_PULSE: begin
        layer_start = NUM_LAYERS'(1) << r_k;
        w_state_nxt = S_WAIT;
      end
      S_WAIT:  if (w_layer_fin) w_state_nxt = (r_k == K_LAST) ? S_DONE : S_PULSE;
      S_DONE:  ;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_clear) w_state_nxt = S_IDLE;
  end

  assign w_status = DATA_W'({r_err, w_done, w_busy, w_all_ne, w_in_ne});
  assign w_final_word = FINAL_IS_A ? r_buf_a[r_rptr[ACT_AW-1:0]]
                                   : r_buf_b[r_rptr[ACT_AW-1:0]];

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_STATUS: w_rd_mux = w_status;
      ADDR_RESULT: if (w_rd_result) w_rd_mux = w_final_word;
      ADDR_RCOUNT: w_rd_mux = DATA_W'(r_result_count);
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_k            <= '0;
      r_in_ptr       <= '0;
      r_result_count <= '0;
      r_rptr         <= '0;
      r_err          <= 1'b0;
      r_readdata     <= '0;
      for (int r = 0; r < NUM_LAYERS; r++) r_wt_ptr[r] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_err_set) r_err <= 1'b1;
      if (w_in_we) r_in_ptr <= r_in_ptr + ACT_ONE;
      for (int r = 0; r < NUM_LAYERS; r++)
        if (w_wt_we[r]) r_wt_ptr[r] <= r_wt_ptr[r] + WT_ONE;
      if (w_start) begin
        r_k            <= '0;
        r_result_count <= '0;
      end
      if (w_layer_fin && (r_k != K_LAST)) r_k <= r_k + K_ONE;
      // Result length tracks the highest address the final layer wrote.
      if (w_out_we && (r_k == K_LAST) && (w_out_cnt > r_result_count))
        r_result_count <= w_out_cnt;
      if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) r_rptr <= '0;
      if (w_rd_result) r_rptr <= r_rptr + ACT_ONE;
      if (w_rd) r_readdata <= w_rd_mux;
      if (w_clear) begin
        r_in_ptr       <= '0;
        r_err          <= 1'b0;
        r_result_count <= '0;
        r_rptr         <= '0;
        for (int r = 0; r < NUM_LAYERS; r++) r_wt_ptr[r] <= '0;
      end
    end
  end

  // Memories. Host writes to A and layer writes are exclusive in time:
  // host data writes are dropped while busy, layer writes only land in WAIT.
  always_ff @(posedge clk) begin
    if (w_in_we) r_buf_a[r_in_ptr[ACT_AW-1:0]] <= writedata;
    if (w_out_we && r_k[0])  r_buf_a[out_wr_addr] <= out_wr_data;
    if (w_out_we && !r_k[0]) r_buf_b[out_wr_addr] <= out_wr_data;
    for (int r = 0; r < NUM_LAYERS; r++)
      if (w_wt_we[r]) r_wt_mem[r][r_wt_ptr[r][WT_AW-1:0]] <= writedata;
    r_act_rd_data <= r_k[0] ? r_buf_b[act_rd_addr] : r_buf_a[act_rd_addr];
    r_wt_rd_data  <= r_wt_mem[r_k][wt_rd_addr];
  end

  assign readdata    = r_readdata;
  assign act_rd_data = r_act_rd_data;
  assign wt_rd_data  = r_wt_rd_data;

endmodule

// File: doc/cnn_mem_seq.md
Name: cnn_mem_seq

Overview:
- Parametrised successor to the single-shot CNN memory block.
- Holds the input image and per-layer weight regions loaded over the host register interface.
- Sequences NUM_LAYERS external compute layers via start/done handshakes and ping-pongs activations between two buffers.
- Exposes the final layer's result to the host as an auto-incrementing read stream with a word count.

Parameters:
DATA_W, 8, width of every stored word and of the host data bus
NUM_LAYERS, 4, number of sequenced layers (1..7); weight region r (1..NUM_LAYERS) belongs to layer r-1
ACT_DEPTH, 16384, words per activation buffer (power of 2); ACT_AW = $clog2(ACT_DEPTH)
WT_DEPTH, 16384, words per weight region (power of 2); WT_AW = $clog2(WT_DEPTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
chipselect  in  1  host select
write  in  1  host write strobe, qualified by chipselect
read  in  1  host read strobe, qualified by chipselect
address  in  4  host register index
writedata  in  DATA_W  host write data
readdata  out  DATA_W  host read data, registered
layer_start  out  NUM_LAYERS  one-hot start pulse to layer k
layer_done  in  NUM_LAYERS  done pulse from layer k
act_rd_addr  in  ACT_AW  current layer's activation read address
act_rd_data  out  DATA_W  activation read data
wt_rd_addr  in  WT_AW  current layer's weight read address
wt_rd_data  out  DATA_W  weight read data
out_wr_en  in  1  current layer's output write enable
out_wr_addr  in  ACT_AW  output write address
out_wr_data  in  DATA_W  output write data

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- State reset by reset: readdata=0, layer_start=0, FSM=IDLE, all write pointers=0, layer k=0, result_count=0, result read pointer=0, err=0.
- State not reset: memory contents.
- Host address map:
  - 0: input stream; writes go to buffer A.
  - 1..NUM_LAYERS: weight stream for region r.
  - 8: control (write only).
  - 9: status (read only).
  - 10: result stream (read only).
  - 11: result_count (read only; low DATA_W bits).
  - Any other address: writes ignored, reads return 0.
- Stream writes: store at region[ptr], then ptr++.
  - Write when ptr==depth: dropped, err set.
  - Any host data write while BUSY: dropped, err set.
  - Region is "nonempty" when ptr>0.
- Control write:
  - bit1 clear: zero all pointers, err, result_count and read pointer; FSM -> IDLE. Ignored (err set) while BUSY.
  - bit0 start: accepted only in IDLE with every region nonempty; otherwise ignored and err set.
  - bit1 and bit0 together: clear wins, start ignored.
- Status read: bit0 input nonempty, bit1 all weight regions nonempty, bit2 busy, bit3 done, bit4 err (sticky), remaining bits 0.
- readdata: updates one cycle after a chipselect&read; holds its value otherwise.
- FSM:
  - IDLE -start-> PULSE (k=0).
  - PULSE: layer_start[k]=1 for exactly one cycle -> WAIT.
  - WAIT: on layer_done[k]: if k==NUM_LAYERS-1 -> DONE; else k++ -> PULSE.
  - layer_done bits other than k are ignored.
  - DONE -clear-> IDLE. start in DONE is rejected with err, because buffer A has been overwritten.
  - busy = PULSE|WAIT.
- Ping-pong buffers:
  - Layer k reads buffer (k even ? A : B) and writes the other buffer.
  - Weight port reads region k+1.
  - Read ports: 1-cycle latency, valid in WAIT only; data outside WAIT is don't-care.
  - out_wr_en is ignored outside WAIT.
- Result:
  - Final buffer = (NUM_LAYERS even ? A : B).
  - During layer NUM_LAYERS-1, result_count = max(out_wr_addr)+1 over all accepted writes.
  - Read pointer resets on entering DONE.
- Result stream read (address 10):
  - Outside DONE: returns 0.
  - In DONE: returns final[rptr], rptr++.
  - Once rptr==result_count: returns 0, rptr holds.
- Reset mid-run: layer_start drops immediately; a late layer_done is ignored in IDLE.

Test Plan:
1. Reset, write 3 input words plus 1 word to each region, start=1 -> layer_start=0001 pulses for 1 cycle; status busy=1, err=0.
2. NUM_LAYERS=4 mock layers, each writes out[i]=in[i]+weight[0] for i<3; input {1,2,3}, weights {1,2,3,4} -> result stream returns {11,12,13} then 0; result_count=3; done=1.
3. WT_DEPTH=4: write 5 words to region 2 -> 5th dropped, err=1, region 2 holds only the first 4 words.
4. start with region 3 empty -> no layer_start pulse, err=1, FSM stays IDLE; write to address 0 during WAIT -> dropped, err=1.
5. layer_done=0010 while k=0 -> ignored; then layer_done=0001 -> layer_start=0010 one cycle later.
6. Assert reset during WAIT of layer 2 -> layer_start=0, status reads 0, pointers 0; a subsequent layer_done pulse has no effect.
